// File: rtl/wave_shaper_pkg.sv
// Shared definitions for the waveform shaper: shape codes, quadrant
// encoding and the elaboration-time quarter-cosine table builder.
package wave_shaper_pkg;

  localparam logic [2:0] MODE_SAW_UP = 3'b000;
  localparam logic [2:0] MODE_SAW_DN = 3'b001;
  localparam logic [2:0] MODE_SQUARE = 3'b010;
  localparam logic [2:0] MODE_COS    = 3'b011;
  localparam logic [2:0] MODE_TRI    = 3'b100;

  // Quadrant = top two phase bits
  localparam logic [1:0] QUAD_0 = 2'b00;
  localparam logic [1:0] QUAD_1 = 2'b01;
  localparam logic [1:0] QUAD_2 = 2'b10;
  localparam logic [1:0] QUAD_3 = 2'b11;

  localparam real PI = 3.14159265358979323846;

  // Entry k of the quarter-cosine table:
  // round((2^(amp_w-1)-1) * cos(pi*k / (2*2^(phase_w-2)))).
  // The cosine is a Taylor series so the table needs nothing beyond
  // real arithmetic during elaboration; 12 terms are exact to well below
  // one LSB over 0..pi/2. The result is never negative, so +0.5 and
  // truncation round to nearest.
  function automatic int cos_quarter(input int k, input int phase_w, input int amp_w);
    real x;
    real term;
    real c;
    real scale;
    int  n;
    n     = 1 << (phase_w - 2);
    x     = PI * real'(k) / (2.0 * real'(n));
    term  = 1.0;
    c     = 1.0;
    for (int i = 1; i <= 12; i++) begin
      term = -term * x * x / ((2.0 * real'(i) - 1.0) * (2.0 * real'(i)));
      c    = c + term;
    end
    scale = real'((1 << (amp_w - 1)) - 1);
    return $rtoi(scale * c + 0.5);
  endfunction

endpackage

// File: rtl/wave_cos_lut.sv
// Quarter-wave cosine lookup with quadrant fold and a registered output.
// This register is the cosine path's second pipeline stage.
module wave_cos_lut
  import wave_shaper_pkg::*;
#(
  parameter int PHASE_W = 8,
  parameter int AMP_W   = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [1:0]         quad,
  input  logic [PHASE_W-3:0] addr,
  output logic [AMP_W-1:0]   amp
);

  localparam int N = 1 << (PHASE_W - 2);
  localparam logic [AMP_W-1:0] MID = AMP_W'(1) << (AMP_W - 1);

  logic [AMP_W-1:0]   qtab [0:N];
  logic [PHASE_W-2:0] idx;
  logic [AMP_W-1:0]   q;
  logic [AMP_W-1:0]   folded;

  for (genvar i = 0; i <= N; i++) begin : g_tab
    localparam int QV = cos_quarter(i, PHASE_W, AMP_W);
    assign qtab[i] = AMP_W'(QV);
  end

  // Odd quadrants read the table mirrored (N-k); quadrants 1 and 2 sit
  // below mid-scale, so the magnitude is subtracted there.
  always_comb begin
    idx = {1'b0, addr};
    if (quad == QUAD_1 || quad == QUAD_3) begin
      idx = (PHASE_W-1)'(N) - {1'b0, addr};
    end
    q = qtab[idx];
    case (quad)
      QUAD_0, QUAD_3: folded = MID + q;
      default:        folded = MID - q;
    endcase
  end

  // Stage 2 register; cleared by reset so a flushed pipe shows 0
  always_ff @(posedge clk) begin
    if (rst) begin
      amp <= '0;
    end else if (en) begin
      amp <= folded;
    end
  end

endmodule

// File: rtl/wave_shaper_pipe.sv
// Pipelined phase-to-amplitude shaper: saw up/down, square, cosine,
// triangle. Shape and duty are latched only on a wrap sample, so each
// waveform cycle is produced with a single shape.
// Optional macro WAVE_SHAPER_GAIN_EN adds the gain port and a third
// stage that scales the output by (gain+1)/256.
module wave_shaper_pipe
  import wave_shaper_pkg::*;
#(
  parameter int PHASE_W = 8,
  parameter int AMP_W   = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic [PHASE_W-1:0] phase_in,
  input  logic [2:0]         mode,
  input  logic [PHASE_W-1:0] duty,
`ifdef WAVE_SHAPER_GAIN_EN
  input  logic [7:0]         gain,
`endif
  output logic               out_valid,
  output logic [AMP_W-1:0]   amplitude,
  output logic               wrap,
  output logic [2:0]         mode_active
);

  logic               first;
  logic [PHASE_W-1:0] prev_phase;
  logic [2:0]         mode_reg;
  logic [PHASE_W-1:0] duty_reg;
  logic               is_wrap;

  logic               vld_p1;
  logic               wrap_p1;
  logic [PHASE_W-1:0] phase_p1;
  logic [AMP_W-1:0]   shape_p1;

  logic               vld_p2;
  logic               wrap_p2;
  logic               sel_cos_p2;
  logic [AMP_W-1:0]   other_p2;
  logic [AMP_W-1:0]   cos_p2;
  logic [AMP_W-1:0]   raw_p2;

  function automatic logic [AMP_W-1:0] saw_up(input logic [PHASE_W-1:0] ph);
    return AMP_W'(ph) << (AMP_W - PHASE_W);
  endfunction

  function automatic logic [AMP_W-1:0] tri_shape(input logic [PHASE_W-1:0] ph);
    logic [PHASE_W-2:0] t;
    t = ph[PHASE_W-2:0];
    if (ph[PHASE_W-1]) begin
      t = ~t;
    end
    return AMP_W'(t) << (AMP_W - PHASE_W + 1);
  endfunction

  // A fresh stream or a backwards step in phase starts a new cycle;
  // equal phases are a hold, not a wrap.
  assign is_wrap = first || (phase_in < prev_phase);

  // ---- stage 1: wrap decision, shape/duty latch, phase register ----
  // Control state: stage valid, wrap flag and the per-cycle shape settings
  always_ff @(posedge clk) begin
    if (rst) begin
      first    <= 1'b1;
      mode_reg <= MODE_SAW_UP;
      duty_reg <= '0;
      vld_p1   <= 1'b0;
      wrap_p1  <= 1'b0;
    end else begin
      vld_p1  <= in_valid;
      wrap_p1 <= in_valid && is_wrap;
      if (in_valid) begin
        first <= 1'b0;
        if (is_wrap) begin
          mode_reg <= mode;
          duty_reg <= duty;
        end
      end
    end
  end

`ifdef WAVE_SHAPER_GAIN_EN
  logic [7:0] gain_p1;
  logic [7:0] gain_p2;

  // Data carried with each accepted sample
  always_ff @(posedge clk) begin
    if (in_valid) begin
      prev_phase <= phase_in;
      phase_p1   <= phase_in;
      gain_p1    <= gain;
    end
  end
`else
  // Data carried with each accepted sample
  always_ff @(posedge clk) begin
    if (in_valid) begin
      prev_phase <= phase_in;
      phase_p1   <= phase_in;
    end
  end
`endif

  // Non-cosine shapes straight from the stage-1 phase; codes above
  // MODE_TRI fall through to 0.
  always_comb begin
    shape_p1 = '0;
    case (mode_reg)
      MODE_SAW_UP: shape_p1 = saw_up(phase_p1);
      MODE_SAW_DN: shape_p1 = ~saw_up(phase_p1);
      MODE_SQUARE: shape_p1 = (phase_p1 < duty_reg) ? '1 : '0;
      MODE_TRI:    shape_p1 = tri_shape(phase_p1);
      default:     shape_p1 = '0;
    endcase
  end

  // ---- stage 2: LUT read / fold and shape mux ----
  wave_cos_lut #(
    .PHASE_W (PHASE_W),
    .AMP_W   (AMP_W)
  ) u_cos_lut (
    .clk  (clk),
    .rst  (rst),
    .en   (vld_p1),
    .quad (phase_p1[PHASE_W-1:PHASE_W-2]),
    .addr (phase_p1[PHASE_W-3:0]),
    .amp  (cos_p2)
  );

  // Stage-2 registers; only loaded on a valid sample so outputs hold
  // through input gaps
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p2     <= 1'b0;
      wrap_p2    <= 1'b0;
      sel_cos_p2 <= 1'b0;
      other_p2   <= '0;
    end else begin
      vld_p2  <= vld_p1;
      wrap_p2 <= wrap_p1;
      if (vld_p1) begin
        sel_cos_p2 <= (mode_reg == MODE_COS);
        other_p2   <= shape_p1;
      end
    end
  end

  assign raw_p2 = sel_cos_p2 ? cos_p2 : other_p2;

`ifdef WAVE_SHAPER_GAIN_EN
  logic             vld_p3;
  logic             wrap_p3;
  logic [AMP_W-1:0] amp_p3;

  // (raw * (gain+1)) >> 8; the product width leaves no room for overflow
  function automatic logic [AMP_W-1:0] apply_gain(input logic [AMP_W-1:0] raw,
                                                  input logic [7:0]       g);
    logic [AMP_W+8:0] prod;
    prod = (AMP_W+9)'(raw) * (AMP_W+9)'({1'b0, g} + 9'd1);
    return AMP_W'(prod >> 8);
  endfunction

  // Gain value travels alongside its sample
  always_ff @(posedge clk) begin
    if (vld_p1) begin
      gain_p2 <= gain_p1;
    end
  end

  // ---- stage 3: gain multiply ----
  // Output register, cleared on reset and held between valid samples
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p3  <= 1'b0;
      wrap_p3 <= 1'b0;
      amp_p3  <= '0;
    end else begin
      vld_p3  <= vld_p2;
      wrap_p3 <= wrap_p2;
      if (vld_p2) begin
        amp_p3 <= apply_gain(raw_p2, gain_p2);
      end
    end
  end

  assign out_valid = vld_p3;
  assign wrap      = wrap_p3;
  assign amplitude = amp_p3;
`else
  assign out_valid = vld_p2;
  assign wrap      = wrap_p2;
  assign amplitude = raw_p2;
`endif

  assign mode_active = mode_reg;

endmodule
